eth_tx_frame: RTL and testbench
===============================

Name: eth_tx_frame

Overview:
GMII-side byte transmitter for the Ethernet path, clocked by the PLL TX clock.
- Host writes a frame payload (DA..payload, no preamble/FCS) into an internal word buffer, then issues a start command.
- Block emits preamble, SFD, payload, optional pad, CRC-32 FCS and inter-packet gap on an 8-bit tx_data/tx_en pair that feeds the DDR output stage.
- Raises a one-cycle tx interrupt on completion.

Parameters:
- BUF_AW, 8, word address width of the payload buffer (2^BUF_AW 32-bit words).
- MAX_LEN, 1024, maximum payload bytes; larger lengths are clamped.
- IPG_LEN, 12, inter-packet gap in byte times.

Ports:
- i_tx_clk  in  1  TX byte clock (125 MHz); the block's single clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- i_tx_wr  in  1  Buffer write strobe.
- i_tx_wr_addr  in  8  Buffer word address.
- i_tx_wr_data  in  32  Buffer word; byte0 = [7:0] is sent first.
- i_cmd_wr  in  1  Command write strobe.
- i_cmd_addr  in  8  Command address; 8'h01 = START.
- i_cmd_data  in  32  For START: [10:0] = payload length in bytes.
- o_tx_data  out  8  GMII byte.
- o_tx_en  out  1  GMII enable.
- o_busy  out  1  High from accepted START until IPG ends.
- o_irq_tx  out  1  One-cycle pulse at frame completion.

Behaviour:
- Reset values: o_tx_data=0, o_tx_en=0, o_busy=0, o_irq_tx=0, FSM=IDLE, CRC=32'hFFFFFFFF. Reset asserted mid-frame aborts immediately; tx_en drops asynchronously.
- Buffer: simple dual-port RAM with 1-cycle synchronous read. Writes are always accepted; writes while o_busy=1 corrupt the frame in flight (host responsibility, not checked).
- START is accepted only when FSM=IDLE and length!=0. Otherwise it is ignored: no error, no irq.
- Length above MAX_LEN is clamped to MAX_LEN.
- FSM: IDLE -> PRE (7 bytes 8'h55) -> SFD (8'hD5) -> DATA (len bytes) -> [PAD] -> FCS (4 bytes) -> IPG (IPG_LEN cycles, tx_en=0, tx_data=0) -> IDLE.
- Latency: START sampled at edge N gives the first 8'h55 with tx_en=1 registered at edge N+1. tx_en stays high continuously from the first preamble byte to the last FCS byte.
- Buffer prefetch: word 0 is read during PRE. Byte lane selected by byte_cnt[1:0]; next word is read when lane 3 is presented.
- CRC: IEEE 802.3, reflected, poly 32'hEDB88320, init all-ones, covers DATA and PAD bytes. FCS = ~CRC, sent LSB byte first.
- byte_cnt is 11 bits; DATA terminates when byte_cnt == len-1. Odd lengths (len mod 4 != 0) ignore the unused lanes of the last word.
- o_irq_tx pulses for the single cycle of the IPG->IDLE transition. o_busy falls on the same edge.
- A START in that same cycle is ignored (FSM not yet IDLE).
- Back-to-back frames: next START is accepted the cycle after o_busy falls.

Optional Feature:
- Macro ETH_TX_PAD_EN.
- Defined: if len<60, PAD state emits 8'h00 bytes until 60 bytes total, included in the CRC; wire frame is >= 64 bytes excluding preamble.
- Undefined: PAD state absent; short payloads are sent as-is (runt allowed; used by loopback tests).

Decomposition:
- Package eth_pkg holds:
  - state enum tx_state_t {IDLE, PRE, SFD, DATA, PAD, FCS, IPG}
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF, ETH_MIN_PAYLOAD=60, CMD_TX_START=8'h01.
- Sub-module eth_crc32: byte-wide combinational next-CRC function with a registered accumulator, init/enable inputs. Reusable by the RX checker.

Test Plan:
- Reset then idle: o_tx_en=0, o_irq_tx=0 for 100 cycles; START with len=0 produces no activity.
- PAD off, buffer word0=32'h34333231, word1=32'h38373635, word2=32'h00000039, START len=9:
  - expect 55x7, D5, 31..39, then FCS 26 39 F4 CB;
  - tx_en high for exactly 21 cycles;
  - 12 idle cycles, then o_irq_tx pulse.
- PAD on, same buffer, START len=9: 51 zero pad bytes follow 39; tx_en high 72 cycles; FCS matches the reference model over 60 bytes.
- START len=1500: clamped to 1024 bytes; FCS matches the model computed over 1024 bytes.
- START while busy: second command ignored, a single frame is sent. START issued the cycle after o_busy falls starts the next frame's preamble immediately.
- rst_n asserted during the DATA byte 5: tx_en=0 at once. After release, a new START sends a full correct frame from the preamble.

Source files
------------

// File: rtl/eth_tx_frame_pkg.sv
// Shared types, constants and the byte-wide CRC-32 step for the Ethernet TX/RX path.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IPG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam int          ETH_MIN_PAYLOAD = 60;
  localparam logic [7:0]  CMD_TX_START    = 8'h01;

  // Reflected CRC-32: data bits enter LSB first, shifting right.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_frame_if.sv
// Host-side buffer/command bus and GMII-side outputs of the frame transmitter.
interface eth_tx_frame_if;
  logic        i_tx_wr;
  logic [7:0]  i_tx_wr_addr;
  logic [31:0] i_tx_wr_data;
  logic        i_cmd_wr;
  logic [7:0]  i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_en;
  logic        o_busy;
  logic        o_irq_tx;

  modport master (
    output i_tx_wr, i_tx_wr_addr, i_tx_wr_data, i_cmd_wr, i_cmd_addr, i_cmd_data,
    input  o_tx_data, o_tx_en, o_busy, o_irq_tx
  );

  modport slave (
    input  i_tx_wr, i_tx_wr_addr, i_tx_wr_data, i_cmd_wr, i_cmd_addr, i_cmd_data,
    output o_tx_data, o_tx_en, o_busy, o_irq_tx
  );
endinterface

// File: rtl/eth_crc32.sv
// Byte-serial IEEE 802.3 CRC-32 accumulator; shared between the TX generator and RX checker.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (i_init) begin
      crc_d = ETH_CRC_INIT;
    end else if (i_en) begin
      crc_d = crc32_byte(crc_q, i_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= ETH_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/eth_tx_frame.sv
// GMII byte transmitter: preamble, SFD, buffered payload, optional pad, FCS and IPG.
// Build option: define ETH_TX_PAD_EN to pad short payloads to the 60-byte minimum.
module eth_tx_frame
  import eth_pkg::*;
#(
  parameter int BUF_AW  = 8,
  parameter int MAX_LEN = 1024,
  parameter int IPG_LEN = 12
) (
  input  logic          i_tx_clk,
  input  logic          rst_n,
  eth_tx_frame_if.slave bus
);

  tx_state_t state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;

  logic [31:0] mem [2**BUF_AW];
  logic [31:0] rd_data_q;
  logic        rd_en;
  logic [BUF_AW-1:0] rd_addr;
  logic [8:0]  word_nxt;

  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_byte;
  logic [31:0] crc_val;
  logic [31:0] fcs_word;
  logic [7:0]  lane_byte;
  logic [7:0]  fcs_byte;
  logic        start;
  logic [10:0] cmd_len;
  logic [10:0] clamped_len;
  logic        unused_bits;

  assign unused_bits = ^{bus.i_cmd_data[31:11], word_nxt[8]};

  always_ff @(posedge i_tx_clk) begin
    if (bus.i_tx_wr) begin
      mem[bus.i_tx_wr_addr[BUF_AW-1:0]] <= bus.i_tx_wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  eth_crc32 u_crc (
    .clk    (i_tx_clk),
    .rst_n  (rst_n),
    .i_init (crc_init),
    .i_en   (crc_en),
    .i_data (crc_byte),
    .o_crc  (crc_val)
  );

  assign start       = bus.i_cmd_wr && (bus.i_cmd_addr == CMD_TX_START);
  assign cmd_len     = bus.i_cmd_data[10:0];
  assign clamped_len = (cmd_len > 11'(MAX_LEN)) ? 11'(MAX_LEN) : cmd_len;
  assign word_nxt    = byte_cnt_q[10:2] + 9'd1;
  assign fcs_word    = ~crc_val;

  always_comb begin
    case (byte_cnt_q[1:0])
      2'd0:    lane_byte = rd_data_q[7:0];
      2'd1:    lane_byte = rd_data_q[15:8];
      2'd2:    lane_byte = rd_data_q[23:16];
      default: lane_byte = rd_data_q[31:24];
    endcase
    case (byte_cnt_q[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  // Outputs are computed from the current state and registered, so the wire lags state by one cycle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    tx_data_d  = 8'h00;
    tx_en_d    = 1'b0;
    irq_d      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_byte   = 8'h00;

    case (state_q)
      IDLE: begin
        crc_init = 1'b1;
        if (start && (cmd_len != 11'd0)) begin
          len_d      = clamped_len;
          byte_cnt_d = 11'd0;
          state_d    = PRE;
        end
      end
      PRE: begin
        tx_data_d = ETH_PREAMBLE;
        tx_en_d   = 1'b1;
        rd_en     = 1'b1;
        if (byte_cnt_q == 11'd6) begin
          byte_cnt_d = 11'd0;
          state_d    = SFD;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
      SFD: begin
        tx_data_d  = ETH_SFD;
        tx_en_d    = 1'b1;
        byte_cnt_d = 11'd0;
        state_d    = DATA;
      end
      DATA: begin
        tx_data_d = lane_byte;
        tx_en_d   = 1'b1;
        crc_en    = 1'b1;
        crc_byte  = lane_byte;
        if (byte_cnt_q[1:0] == 2'd3) begin
          rd_en   = 1'b1;
          rd_addr = word_nxt[BUF_AW-1:0];
        end
        if (byte_cnt_q == len_q - 11'd1) begin
`ifdef ETH_TX_PAD_EN
          if (len_q < 11'(ETH_MIN_PAYLOAD)) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            state_d    = PAD;
          end else begin
            byte_cnt_d = 11'd0;
            state_d    = FCS;
          end
`else
          byte_cnt_d = 11'd0;
          state_d    = FCS;
`endif
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        tx_data_d = 8'h00;
        tx_en_d   = 1'b1;
        crc_en    = 1'b1;
        crc_byte  = 8'h00;
        if (byte_cnt_q == 11'(ETH_MIN_PAYLOAD - 1)) begin
          byte_cnt_d = 11'd0;
          state_d    = FCS;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
`endif
      FCS: begin
        tx_data_d = fcs_byte;
        tx_en_d   = 1'b1;
        if (byte_cnt_q == 11'd3) begin
          byte_cnt_d = 11'd0;
          state_d    = IPG;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
      IPG: begin
        if (byte_cnt_q == 11'(IPG_LEN - 1)) begin
          byte_cnt_d = 11'd0;
          irq_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge i_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= 11'd0;
      len_q      <= 11'd0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.o_tx_data = tx_data_q;
  assign bus.o_tx_en   = tx_en_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_irq_tx  = irq_q;

endmodule

// File: tb/tb_eth_tx_frame.sv
// Randomized self-checking bench for eth_tx_frame against a byte-queue frame model.
module tb_eth_tx_frame;
  import eth_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  eth_tx_frame_if bus();

  eth_tx_frame dut (
    .i_tx_clk (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] model_mem [256];
  logic [31:0] crc_tab [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int lat, en_cycles, gap;
  bit irq_seen, busy_ok;

  task automatic init_crc_table();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  // Reference frame: preamble, SFD, payload (clamped, optionally padded), table-driven FCS.
  task automatic build_expected(input int len);
    logic [7:0]  pl[$];
    logic [31:0] c;
    int n;
    n = (len > 1024) ? 1024 : len;
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'(model_mem[i / 4] >> (8 * (i % 4))));
    while (PAD_ON && pl.size() < 60) pl.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (pl[i]) c = crc_tab[c[7:0] ^ pl[i]] ^ (c >> 8);
    c = ~c;
    exp_q = {};
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    bus.i_tx_wr      = 1'b1;
    bus.i_tx_wr_addr = 8'(a);
    bus.i_tx_wr_data = d;
    @(negedge clk);
    bus.i_tx_wr = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic fill_random(input int len);
    for (int w = 0; w < (len + 3) / 4; w++) write_word(w, $urandom);
  endtask

  task automatic send_start(input logic [31:0] d);
    bus.i_cmd_wr   = 1'b1;
    bus.i_cmd_addr = CMD_TX_START;
    bus.i_cmd_data = d;
    @(negedge clk);
    bus.i_cmd_wr = 1'b0;
  endtask

  // Collects one frame; optionally pokes a START in the last IPG cycle before the irq.
  task automatic capture_frame(input int bound, input bit poke_late, input logic [31:0] poke_len);
    got_q = {};
    lat = 0; en_cycles = 0; gap = 0; irq_seen = 0; busy_ok = 1;
    while (!bus.o_tx_en && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.o_tx_en) return;
    while (bus.o_tx_en && en_cycles < bound) begin
      got_q.push_back(bus.o_tx_data);
      en_cycles++;
      if (!bus.o_busy) busy_ok = 0;
      @(negedge clk);
    end
    gap = 1;
    while (!bus.o_irq_tx && gap < bound) begin
      if (bus.o_tx_en || !bus.o_busy) busy_ok = 0;
      if (poke_late) begin
        bus.i_cmd_wr   = (gap == 11);
        bus.i_cmd_addr = CMD_TX_START;
        bus.i_cmd_data = poke_len;
      end
      @(negedge clk);
      gap++;
    end
    if (poke_late) bus.i_cmd_wr = 1'b0;
    if (bus.o_irq_tx) begin
      irq_seen = 1;
      if (bus.o_busy || bus.o_tx_en) busy_ok = 0;
    end
  endtask

  task automatic check_frame(input string name);
    int mism;
    total++;
    if (lat !== 1) begin
      bad++;
      $display("[TB] FAIL %s latency: got %0d cycles, want 1", name, lat);
    end
    mism = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        mism = i;
        break;
      end
    end
    total++;
    if (got_q.size() != exp_q.size() || mism >= 0) begin
      bad++;
      $display("[TB] FAIL %s bytes: got len %0d, want len %0d, first diff idx %0d got %h want %h",
               name, got_q.size(), exp_q.size(), mism,
               (mism >= 0) ? got_q[mism] : 8'h00, (mism >= 0) ? exp_q[mism] : 8'h00);
    end
    total++;
    if (gap !== 12) begin
      bad++;
      $display("[TB] FAIL %s ipg: got irq %0d cycles after last byte, want 12", name, gap);
    end
    total++;
    if (!(irq_seen && busy_ok)) begin
      bad++;
      $display("[TB] FAIL %s irq/busy: got irq_seen=%0d busy_ok=%0d, want 1 1", name, irq_seen, busy_ok);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit active;
    active = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.o_tx_en || bus.o_irq_tx || bus.o_busy) active = 1;
    end
    total++;
    if (active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s: got activity=%0d, want 0", name, active);
    end
  endtask

  task automatic test_reset();
    bus.i_tx_wr = 0; bus.i_tx_wr_addr = 0; bus.i_tx_wr_data = 0;
    bus.i_cmd_wr = 0; bus.i_cmd_addr = 0; bus.i_cmd_data = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.o_tx_data, bus.o_tx_en, bus.o_busy, bus.o_irq_tx} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset outputs: got %h, want 000", {bus.o_tx_data, bus.o_tx_en, bus.o_busy, bus.o_irq_tx});
    end
    rst_n = 1'b1;
    expect_quiet("idle_100", 100);
    send_start(32'd0);
    expect_quiet("start_len0", 30);
  endtask

  task automatic test_known_frame();
    write_word(0, 32'h34333231);
    write_word(1, 32'h38373635);
    write_word(2, 32'h00000039);
    build_expected(9);
    send_start(32'd9);
    capture_frame(200, 0, 0);
    check_frame("known");
    total++;
`ifndef ETH_TX_PAD_EN
    if ({got_q[17], got_q[18], got_q[19], got_q[20]} !== 32'h2639F4CB || en_cycles !== 21) begin
      bad++;
      $display("[TB] FAIL known fcs/len: got %h%h%h%h en=%0d, want 2639f4cb en=21",
               got_q[17], got_q[18], got_q[19], got_q[20], en_cycles);
    end
`else
    if (en_cycles !== 72) begin
      bad++;
      $display("[TB] FAIL known padded len: got en=%0d, want 72", en_cycles);
    end
`endif
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 4; it++) begin
      int len;
      logic [31:0] cmd;
      len = $urandom_range(1, 130);
      fill_random(len);
      build_expected(len);
      cmd = $urandom;
      cmd[10:0] = 11'(len);
      send_start(cmd);
      capture_frame(400, 0, 0);
      check_frame($sformatf("random%0d", it));
    end
  endtask

  task automatic test_clamp();
    for (int w = 0; w < 256; w++) write_word(w, $urandom);
    build_expected(1500);
    send_start(32'd1500);
    capture_frame(1500, 0, 0);
    check_frame("clamp");
    total++;
    if (en_cycles !== 8 + 1024 + 4) begin
      bad++;
      $display("[TB] FAIL clamp length: got en=%0d, want %0d", en_cycles, 8 + 1024 + 4);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(20);
    build_expected(20);
    send_start(32'd20);
    fork
      begin
        repeat (8) @(negedge clk);
        bus.i_cmd_wr   = 1'b1;
        bus.i_cmd_addr = CMD_TX_START;
        bus.i_cmd_data = 32'd7;
        @(negedge clk);
        bus.i_cmd_wr = 1'b0;
      end
      capture_frame(300, 1, 32'd5);
    join
    check_frame("busy_ignore");
    expect_quiet("after_busy_ignore", 30);
    send_start(32'd20);
    capture_frame(300, 0, 0);
    check_frame("b2b_first");
    send_start(32'd20);
    capture_frame(300, 0, 0);
    check_frame("b2b_second");
  endtask

  task automatic test_reset_mid();
    int seen;
    fill_random(40);
    build_expected(40);
    send_start(32'd40);
    seen = 0;
    for (int c = 0; c < 100 && seen < 13; c++) begin
      @(negedge clk);
      if (bus.o_tx_en) seen++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (seen !== 13 || bus.o_tx_en !== 1'b0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got seen=%0d tx_en=%b busy=%b, want 13 0 0", seen, bus.o_tx_en, bus.o_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_start(32'd40);
    capture_frame(300, 0, 0);
    check_frame("after_reset");
  endtask

  initial begin
    init_crc_table();
    test_reset();
    test_known_frame();
    test_random_frames();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
